// File: rtl/writeback_reorder_l2_pkg.sv
// writeback_reorder_l2_pkg: shared field widths and the buffered writeback record
package writeback_reorder_l2_pkg;

   localparam int pc_bits    = 32;
   localparam int waddr_bits = 5;
   localparam int wdata_bits = 32;

   // One buffered X->W result; seq_num is implied by the slot it lives in
   typedef struct packed {
      logic [pc_bits-1:0]    pc;
      logic [waddr_bits-1:0] waddr;
      logic [wdata_bits-1:0] wdata;
      logic                  wen;
   } wb_entry_t;

endpackage

// File: rtl/writeback_reorder_l2.sv
// writeback_reorder_l2: reorders out-of-order execute results into in-order commits
module writeback_reorder_l2
   import writeback_reorder_l2_pkg::*;
#(
   parameter int p_seq_num_bits = 5,
   parameter int p_num_pipes    = 2
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [p_num_pipes-1:0]                         ex_val,
   output logic [p_num_pipes-1:0]                         ex_rdy,
   input  logic [p_num_pipes-1:0][pc_bits-1:0]            ex_pc,
   input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]     ex_seq_num,
   input  logic [p_num_pipes-1:0][waddr_bits-1:0]         ex_waddr,
   input  logic [p_num_pipes-1:0][wdata_bits-1:0]         ex_wdata,
   input  logic [p_num_pipes-1:0]                         ex_wen,
   output logic                                           commit_val,
   input  logic                                           commit_rdy,
   output logic [pc_bits-1:0]                             commit_pc,
   output logic [p_seq_num_bits-1:0]                      commit_seq_num,
   output logic [waddr_bits-1:0]                          commit_waddr,
   output logic [wdata_bits-1:0]                          commit_wdata,
   output logic                                           commit_wen
);

   localparam int                  n_entries = 1 << p_seq_num_bits;
   localparam logic [p_seq_num_bits-1:0] seq_one = 1;

   logic [n_entries-1:0]      valid;
   wb_entry_t                 mem [n_entries];
   logic [p_seq_num_bits-1:0] head;
   logic [p_num_pipes-1:0]    ex_fire;
   logic                      commit_fire;

   // A pipe may write only a free slot, and loses to any lower pipe aiming at the same slot
   always_comb begin
      ex_rdy = '0;
      for (int i = 0; i < p_num_pipes; i++) begin
         ex_rdy[i] = rst && !valid[ex_seq_num[i]];
         for (int j = 0; j < i; j++)
            if (ex_val[j] && ex_seq_num[j] == ex_seq_num[i]) ex_rdy[i] = 1'b0;
      end
   end

   assign ex_fire     = ex_val & ex_rdy;
   assign commit_fire = commit_val && commit_rdy;

   // The head slot is presented straight from registered state
   always_comb begin
      commit_val     = valid[head];
      commit_seq_num = head;
      commit_pc      = mem[head].pc;
      commit_waddr   = mem[head].waddr;
      commit_wdata   = mem[head].wdata;
      commit_wen     = mem[head].wen;
   end

   // Valid bits and head pointer; a fired slot is never the committing head, so updates never collide
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         head  <= '0;
      end else begin
         if (commit_fire) begin
            valid[head] <= 1'b0;
            head        <= head + seq_one;
         end
         for (int i = 0; i < p_num_pipes; i++)
            if (ex_fire[i]) valid[ex_seq_num[i]] <= 1'b1;
      end
   end

   // Entry payloads need no reset; the valid bit qualifies them
   always_ff @(posedge clk) begin
      for (int i = 0; i < p_num_pipes; i++)
         if (ex_fire[i])
            mem[ex_seq_num[i]] <= '{pc: ex_pc[i], waddr: ex_waddr[i], wdata: ex_wdata[i], wen: ex_wen[i]};
   end

   function automatic logic [p_seq_num_bits+p_num_pipes:0] trace();
      return {head, commit_val, ex_rdy};
   endfunction

endmodule

// File: tb/tb_writeback_reorder_l2.sv
// tb_writeback_reorder_l2: table, directed and randomized checks of the writeback reorder buffer
module tb_writeback_reorder_l2;

   localparam int sb = 3;
   localparam int np = 2;
   localparam int nw = 8;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic [np-1:0]           ex_val = '0;
   logic [np-1:0]           ex_rdy;
   logic [np-1:0][31:0]     ex_pc = '0;
   logic [np-1:0][sb-1:0]   ex_seq_num = '0;
   logic [np-1:0][4:0]      ex_waddr = '0;
   logic [np-1:0][31:0]     ex_wdata = '0;
   logic [np-1:0]           ex_wen = '0;
   logic                    commit_val;
   logic                    commit_rdy = 1'b1;
   logic [31:0]             commit_pc;
   logic [sb-1:0]           commit_seq_num;
   logic [4:0]              commit_waddr;
   logic [31:0]             commit_wdata;
   logic                    commit_wen;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   writeback_reorder_l2 #(.p_seq_num_bits(sb), .p_num_pipes(np)) dut (
      .clk(clk), .rst(rst),
      .ex_val(ex_val), .ex_rdy(ex_rdy), .ex_pc(ex_pc), .ex_seq_num(ex_seq_num),
      .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_wen(ex_wen),
      .commit_val(commit_val), .commit_rdy(commit_rdy), .commit_pc(commit_pc),
      .commit_seq_num(commit_seq_num), .commit_waddr(commit_waddr),
      .commit_wdata(commit_wdata), .commit_wen(commit_wen)
   );

   typedef struct {
      logic r; logic v0; int s0; logic [31:0] d0; logic v1; int s1; logic [31:0] d1; logic crdy;
      logic e0; logic e1; logic ecv; int es; logic [31:0] ed;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pc_of(input logic [31:0] d);
      return 32'h1000_0000 ^ d;
   endfunction

   function automatic logic [4:0] wa_of(input logic [31:0] d, input int s);
      return d[4:0] ^ 5'(s);
   endfunction

   task automatic drive(input int p, input logic v, input int s, input logic [31:0] d);
      ex_val[p]     = v;
      ex_seq_num[p] = sb'(s);
      ex_wdata[p]   = d;
      ex_pc[p]      = pc_of(d);
      ex_waddr[p]   = wa_of(d, s);
      ex_wen[p]     = d[5];
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      next_cycle();
      rst = 1'b0;
      drive(0, 1'b0, 0, 0);
      drive(1, 1'b0, 0, 0);
      @(negedge clk);
      chk("rst rdy", 64'(ex_rdy), 64'd0);
      chk("rst cval", 64'(commit_val), 64'd0);
      next_cycle();
      rst = 1'b1;
   endtask

   logic [69:0] mq [int];
   int          mhead;

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 0, 32'h0,  1'b1, 1, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 0, 32'h10, 1'b0, 7, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h0};
      tbl[2]  = '{1'b1, 1'b1, 1, 32'h11, 1'b0, 7, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 0, 32'h10};
      tbl[3]  = '{1'b1, 1'b1, 2, 32'h12, 1'b0, 7, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 1, 32'h11};
      tbl[4]  = '{1'b1, 1'b0, 0, 32'h0,  1'b0, 7, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 2, 32'h12};
      tbl[5]  = '{1'b1, 1'b0, 0, 32'h0,  1'b1, 4, 32'hBB, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h0};
      tbl[6]  = '{1'b1, 1'b0, 0, 32'h0,  1'b0, 4, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0};
      tbl[7]  = '{1'b1, 1'b1, 3, 32'hAA, 1'b0, 7, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h0};
      tbl[8]  = '{1'b1, 1'b0, 0, 32'h0,  1'b0, 7, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 3, 32'hAA};
      tbl[9]  = '{1'b1, 1'b0, 0, 32'h0,  1'b0, 7, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 4, 32'hBB};
      tbl[10] = '{1'b1, 1'b0, 0, 32'h0,  1'b0, 7, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h0};
      tbl[11] = '{1'b1, 1'b1, 5, 32'hC0, 1'b1, 5, 32'hC1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0};
      tbl[12] = '{1'b1, 1'b0, 0, 32'h0,  1'b1, 5, 32'hC1, 1'b0, 1'b1, 1'b0, 1'b1, 5, 32'hC0};
      tbl[13] = '{1'b1, 1'b0, 0, 32'h0,  1'b1, 5, 32'hC1, 1'b0, 1'b1, 1'b0, 1'b1, 5, 32'hC0};
      tbl[14] = '{1'b1, 1'b0, 0, 32'h0,  1'b1, 5, 32'hC1, 1'b1, 1'b1, 1'b0, 1'b1, 5, 32'hC0};
      tbl[15] = '{1'b1, 1'b0, 0, 32'h0,  1'b0, 5, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h0};

      repeat (2) @(posedge clk);
      for (int r = 0; r < 16; r++) begin
         next_cycle();
         rst = tbl[r].r;
         drive(0, tbl[r].v0, tbl[r].s0, tbl[r].d0);
         drive(1, tbl[r].v1, tbl[r].s1, tbl[r].d1);
         commit_rdy = tbl[r].crdy;
         @(negedge clk);
         chk($sformatf("tbl%0d rdy0", r), 64'(ex_rdy[0]), 64'(tbl[r].e0));
         chk($sformatf("tbl%0d rdy1", r), 64'(ex_rdy[1]), 64'(tbl[r].e1));
         chk($sformatf("tbl%0d cval", r), 64'(commit_val), 64'(tbl[r].ecv));
         if (tbl[r].ecv) begin
            chk($sformatf("tbl%0d cseq", r), 64'(commit_seq_num), 64'(tbl[r].es));
            chk($sformatf("tbl%0d cdata", r), 64'(commit_wdata), 64'(tbl[r].ed));
         end
      end

      // back-pressure: seq 0 held for five cycles, then released
      do_reset();
      commit_rdy = 1'b0;
      drive(0, 1'b1, 0, 32'h55);
      @(negedge clk);
      chk("bp rdy0", 64'(ex_rdy[0]), 64'd1);
      next_cycle();
      drive(0, 1'b0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp cval", 64'(commit_val), 64'd1);
         chk("bp cseq", 64'(commit_seq_num), 64'd0);
         chk("bp cdata", 64'(commit_wdata), 64'h55);
         chk("bp cpc", 64'(commit_pc), 64'(pc_of(32'h55)));
         next_cycle();
      end
      commit_rdy = 1'b1;
      @(negedge clk);
      chk("bp rel cval", 64'(commit_val), 64'd1);
      next_cycle();
      @(negedge clk);
      chk("bp after cval", 64'(commit_val), 64'd0);
      chk("bp after head", 64'(commit_seq_num), 64'd1);

      // mid-operation reset discards buffered seq 2 and 3
      do_reset();
      drive(0, 1'b1, 2, 32'h22);
      drive(1, 1'b1, 3, 32'h33);
      @(negedge clk);
      chk("mr rdy0", 64'(ex_rdy[0]), 64'd1);
      chk("mr rdy1", 64'(ex_rdy[1]), 64'd1);
      next_cycle();
      drive(0, 1'b0, 2, 0);
      drive(1, 1'b0, 0, 0);
      @(negedge clk);
      chk("mr held rdy0", 64'(ex_rdy[0]), 64'd0);
      do_reset();
      drive(0, 1'b0, 2, 0);
      @(negedge clk);
      chk("mr post cval", 64'(commit_val), 64'd0);
      chk("mr post head", 64'(commit_seq_num), 64'd0);
      chk("mr post rdy0", 64'(ex_rdy[0]), 64'd1);
      next_cycle();
      drive(0, 1'b1, 0, 32'h44);
      @(negedge clk);
      next_cycle();
      drive(0, 1'b1, 1, 32'h45);
      @(negedge clk);
      chk("mr c0 cval", 64'(commit_val), 64'd1);
      chk("mr c0 data", 64'(commit_wdata), 64'h44);
      next_cycle();
      drive(0, 1'b0, 0, 0);
      @(negedge clk);
      chk("mr c1 data", 64'(commit_wdata), 64'h45);
      next_cycle();
      @(negedge clk);
      chk("mr gone cval", 64'(commit_val), 64'd0);
      chk("mr gone head", 64'(commit_seq_num), 64'd2);

      // wrap-around: 0..7 then 0..3 streamed in order
      do_reset();
      commit_rdy = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         if (k < 12) drive(0, 1'b1, k % nw, 32'h100 + k);
         else drive(0, 1'b0, 0, 0);
         @(negedge clk);
         if (k < 12) chk($sformatf("wrap%0d rdy0", k), 64'(ex_rdy[0]), 64'd1);
         if (k > 0) begin
            chk($sformatf("wrap%0d cval", k), 64'(commit_val), 64'd1);
            chk($sformatf("wrap%0d cseq", k), 64'(commit_seq_num), 64'((k - 1) % nw));
            chk($sformatf("wrap%0d cdata", k), 64'(commit_wdata), 64'(32'h100 + k - 1));
         end
         next_cycle();
      end
      @(negedge clk);
      chk("wrap end cval", 64'(commit_val), 64'd0);
      chk("wrap end head", 64'(commit_seq_num), 64'd4);

      // randomized traffic against a slot-map reference
      do_reset();
      mhead = 0;
      mq.delete();
      for (int c = 0; c < 3000; c++) begin
         logic        v [np];
         int          s [np];
         logic [31:0] d [np];
         logic        er [np];
         logic        ecv;
         logic [69:0] e;
         for (int p = 0; p < np; p++) begin
            v[p] = 1'($urandom_range(0, 1));
            s[p] = (mhead + int'($urandom_range(0, nw - 1))) % nw;
            d[p] = $urandom;
            drive(p, v[p], s[p], d[p]);
         end
         commit_rdy = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         for (int p = 0; p < np; p++) begin
            er[p] = !mq.exists(s[p]);
            for (int q = 0; q < p; q++) if (v[q] && s[q] == s[p]) er[p] = 1'b0;
            chk($sformatf("rnd%0d rdy%0d", c, p), 64'(ex_rdy[p]), 64'(er[p]));
         end
         ecv = mq.exists(mhead);
         chk($sformatf("rnd%0d cval", c), 64'(commit_val), 64'(ecv));
         if (ecv) begin
            e = mq[mhead];
            chk($sformatf("rnd%0d cseq", c), 64'(commit_seq_num), 64'(mhead));
            chk($sformatf("rnd%0d cpc", c), 64'(commit_pc), 64'(e[69:38]));
            chk($sformatf("rnd%0d cwaddr", c), 64'(commit_waddr), 64'(e[37:33]));
            chk($sformatf("rnd%0d cwdata", c), 64'(commit_wdata), 64'(e[32:1]));
            chk($sformatf("rnd%0d cwen", c), 64'(commit_wen), 64'(e[0]));
            if (commit_rdy) begin
               mq.delete(mhead);
               mhead = (mhead + 1) % nw;
            end
         end
         for (int p = 0; p < np; p++)
            if (v[p] && er[p]) mq[s[p]] = {pc_of(d[p]), wa_of(d[p], s[p]), d[p], d[p][5]};
         next_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/writeback_reorder_l2.md
WRITEBACK_REORDER_L2 -- requirements
Module: WritebackReorderL2

Interface
REQ-001 SHALL have parameter p_seq_num_bits, default 5, giving sequence-number width; the reorder window is 2^p_seq_num_bits entries.
REQ-002 SHALL have parameter p_num_pipes, default 2, giving the number of execute-pipe X__W inputs.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset; state clears while rst is 0.
REQ-005 SHALL have port Ex[p_num_pipes], X__WIntf receiver side (val in, rdy out, pc 32, seq_num p_seq_num_bits, waddr 5, wdata 32, wen 1, all in), completed results from execute units.
REQ-006 SHALL have port commit_val, output, 1, head entry is valid and presented.
REQ-007 SHALL have port commit_rdy, input, 1, consumer accepts the head entry.
REQ-008 SHALL have ports commit_pc (32), commit_seq_num (p_seq_num_bits), commit_waddr (5), commit_wdata (32) and commit_wen (1), all outputs, carrying the head entry fields.

Function
REQ-009 SHALL hold 2^p_seq_num_bits entries indexed directly by seq_num; each entry holds a valid bit plus pc, waddr, wdata and wen.
REQ-010 SHALL hold a head pointer (p_seq_num_bits wide) naming the next seq_num to commit; it is 0 after reset.
REQ-011 SHALL drive Ex[i].rdy = 1 iff entry[Ex[i].seq_num] is not valid and no lower-index pipe presents the same seq_num with val=1.
REQ-012 SHALL write the entry and set its valid bit on a fire (val & rdy) of Ex[i]; several pipes with distinct seq_nums all fire in the same cycle.
REQ-013 SHALL derive rdy from the registered valid bit only; a pipe targeting an entry that is committed this cycle sees rdy=0 and stalls one cycle.
REQ-014 SHALL drive commit_val = entry[head].valid, with commit_* equal to entry[head] fields and commit_seq_num = head; no combinational path from Ex to commit.
REQ-015 SHALL, on commit fire (commit_val & commit_rdy), clear entry[head].valid and increment head modulo 2^p_seq_num_bits (head wraps from 2^p_seq_num_bits-1 to 0).
REQ-016 SHALL have minimum latency 1 cycle: a message firing at edge t appears on commit after edge t, provided its seq_num equals head.
REQ-017 SHALL commit at most one entry per cycle, strictly in seq_num order; a younger entry waits while any older one is missing.
REQ-018 SHALL hold commit_* stable while commit_val=1 and commit_rdy=0.
REQ-019 SHALL accept messages whose seq_num is not head (out of order) and buffer them until head reaches them.
REQ-020 SHALL NOT modify a valid entry; a duplicate seq_num is back-pressured until that entry commits.

Reset
REQ-021 SHALL, while rst=0, clear all entry valid bits, set head=0, and drive commit_val=0 and all Ex[i].rdy=0.
REQ-022 SHALL discard all buffered entries when reset is asserted mid-operation; entry data fields need no reset.
REQ-023 SHALL raise Ex[i].rdy in the first cycle after rst deasserts, subject to REQ-011.

Structure
REQ-024 SHALL take its commit message typedef (pc, seq_num, waddr, wdata, wen) from the shared UArch package, reusing the existing X__WIntf definition.
REQ-025 SHALL keep the head-pointer width equal to the p_seq_num_bits of the connected interfaces.
REQ-026 SHALL be a single module with no sub-module; the entry array and round-robin-free fixed-priority collision logic are inline.
REQ-027 SHALL provide a trace() function in line with the other L2 units.

Verification
REQ-028 SHALL pass in-order: Ex[0] sends seq 0,1,2 (wdata 0x10,0x11,0x12, commit_rdy=1) -> commits seq 0,1,2 on consecutive cycles, 1 cycle after each fire.
REQ-029 SHALL pass out-of-order: Ex[1] sends seq 1 (wdata 0xBB), then Ex[0] sends seq 0 (0xAA) two cycles later -> commit_val stays 0 until seq 0 arrives, then commits 0xAA then 0xBB back-to-back.
REQ-030 SHALL pass simultaneous arrival: Ex[0] sends seq 3 and Ex[1] sends seq 3 in the same cycle -> Ex[0] fires and Ex[1].rdy=0 until seq 3 commits; no data overwrite.
REQ-031 SHALL pass wrap-around: with p_seq_num_bits=3, stream seq 0..7 then 0..3 -> 12 in-order commits, head wraps 7->0, and the values match.
REQ-032 SHALL pass back-pressure: hold commit_rdy=0 for 5 cycles with seq 0 buffered -> commit_* stable and seq 0 committed once commit_rdy=1.
REQ-033 SHALL pass mid-operation reset: buffer seq 2,3 then pulse rst low for 1 cycle -> commit_val=0, head=0, and a new seq 0 commits normally.
